video_stream_source: RTL and testbench



---
 rtl/vsrc_pkg.sv | 34 +++
 rtl/video_stream_source_raster_counter.sv | 57 +++++
 rtl/video_stream_source.sv | 172 +++++++++++++++++
 tb/tb_video_stream_source.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vsrc_pkg.sv
// -----------------------------------------------------------------------------
// vsrc_pkg
// Shared definitions for the video stream source and its raster counter:
//   - state_t       : transmitter state encoding (IDLE, SYNC, RUN)
//   - DEF_*         : default raster timing (858 x 525 total, 640 x 480 active)
//   - log2()        : ceiling log2 used to size counters, minimum result of 1
// -----------------------------------------------------------------------------
package vsrc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_WIDTH     = 858;
    localparam int DEF_HEIGHT    = 525;
    localparam int DEF_W_WIDTH   = 640;
    localparam int DEF_W_HEIGHT  = 480;

    // Number of bits needed to hold the values 0 .. value-1, never less than one.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/video_stream_source_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Free-running WIDTH x HEIGHT raster position generator.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   clear      : forces both counters to 0 on the next edge
//   advance    : step the raster by one pixel
//   hc, vc     : current horizontal / vertical position
//   act        : current position lies inside the W_WIDTH x W_HEIGHT window
//   eof        : current position is the last pixel of the frame
//   origin     : current position is (0,0)
// -----------------------------------------------------------------------------
module raster_counter
    import vsrc_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int W_WIDTH  = DEF_W_WIDTH,
    parameter int W_HEIGHT = DEF_W_HEIGHT,
    localparam int HC_W    = log2(WIDTH),
    localparam int VC_W    = log2(HEIGHT)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            advance,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            act,
    output logic            eof,
    output logic            origin
);

    logic eol;

    assign eol    = (hc == HC_W'(WIDTH - 1));
    assign eof    = eol && (vc == VC_W'(HEIGHT - 1));
    assign act    = (hc < HC_W'(W_WIDTH)) && (vc < VC_W'(W_HEIGHT));
    assign origin = (hc == '0) && (vc == '0);

    // Horizontal count wraps at WIDTH; the vertical count steps on each line
    // wrap and itself wraps at the end of the frame.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hc <= '0;
            vc <= '0;
        end else if (advance) begin
            if (eol) begin
                hc <= '0;
                vc <= eof ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_stream_source.sv
// -----------------------------------------------------------------------------
// video_stream_source
// Raster-stream transmitter: pulls RGB pixels from a valid/ready stream during
// the active window and emits them with their raster position one cycle later.
// Underflow and misaligned start-of-frame markers drop the source back into
// SYNC, which discards pixels until a marked first pixel can be aligned to (0,0).
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   enable                   : run the raster; low returns to IDLE
//   s_valid, s_ready, s_data : upstream pixel stream, s_data = {r,g,b}
//   s_sof                    : marks the first active pixel of a frame
//   r_out, g_out, b_out      : output pixel
//   hcount_out, vcount_out   : position of the output pixel
//   active_out               : output pixel is inside the active window
//   frame_start              : pulse with output pixel (0,0) of an aligned frame
//   underflow, err_clear     : sticky error flag and its clear
// -----------------------------------------------------------------------------
module video_stream_source
    import vsrc_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int W_WIDTH   = DEF_W_WIDTH,
    parameter int W_HEIGHT  = DEF_W_HEIGHT,
    localparam int HC_W     = log2(WIDTH),
    localparam int VC_W     = log2(HEIGHT)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [3*BIT_WIDTH-1:0] s_data,
    input  logic                   s_sof,
    output logic [BIT_WIDTH-1:0]   r_out,
    output logic [BIT_WIDTH-1:0]   g_out,
    output logic [BIT_WIDTH-1:0]   b_out,
    output logic [HC_W-1:0]        hcount_out,
    output logic [VC_W-1:0]        vcount_out,
    output logic                   active_out,
    output logic                   frame_start,
    output logic                   underflow,
    input  logic                   err_clear
);

    state_t                 state;
    state_t                 state_next;
    logic [HC_W-1:0]        hc;
    logic [VC_W-1:0]        vc;
    logic                   act;
    logic                   eof;
    logic                   origin;
    logic                   frame_err;
    logic                   uf_set;
    logic [3*BIT_WIDTH-1:0] pix_next;

    raster_counter #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .W_WIDTH  (W_WIDTH),
        .W_HEIGHT (W_HEIGHT)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (!enable),
        .advance (state != IDLE),
        .hc      (hc),
        .vc      (vc),
        .act     (act),
        .eof     (eof),
        .origin  (origin)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake, pixel selection, error detection and next state. In SYNC a
    // marked pixel is left waiting at the head of the stream so that the
    // RUN frame can consume it at (0,0); unmarked pixels are drained. An
    // accepted marker anywhere but (0,0) in RUN means the frames have slipped.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        uf_set     = 1'b0;
        pix_next   = '0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                s_ready = !origin && !(s_valid && s_sof);
                if (eof && s_valid && s_sof) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                s_ready = act;
                if (act && s_valid) begin
                    if (s_sof && !origin) begin
                        uf_set     = 1'b1;
                        state_next = SYNC;
                    end else begin
                        pix_next = s_data;
                    end
                end else if (act) begin
                    uf_set = 1'b1;
                end
                if (eof && (frame_err || uf_set)) begin
                    state_next = SYNC;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    // Per-frame error memory: decides at end of frame whether RUN must resync.
    always_ff @(posedge clk) begin
        if (rst || (state_next != RUN) || eof) begin
            frame_err <= 1'b0;
        end else if (uf_set) begin
            frame_err <= 1'b1;
        end
    end

    // Output registers: one cycle behind the raster, all zero while idle or
    // while being disabled.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE) || !enable) begin
            r_out       <= '0;
            g_out       <= '0;
            b_out       <= '0;
            hcount_out  <= '0;
            vcount_out  <= '0;
            active_out  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_out       <= pix_next[3*BIT_WIDTH-1:2*BIT_WIDTH];
            g_out       <= pix_next[2*BIT_WIDTH-1:BIT_WIDTH];
            b_out       <= pix_next[BIT_WIDTH-1:0];
            hcount_out  <= hc;
            vcount_out  <= vc;
            active_out  <= act;
            frame_start <= origin && (state == RUN);
        end
    end

    // Sticky underflow: a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (uf_set) begin
            underflow <= 1'b1;
        end else if (err_clear) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_stream_source.sv
// -----------------------------------------------------------------------------
// tb_video_stream_source
// Directed bench on a 10 x 6 raster with a 4 x 3 active window. The upstream
// source cycles through twelve fixed pixels, marking the first with s_sof.
// -----------------------------------------------------------------------------
module tb_video_stream_source;

    localparam int BW     = 8;
    localparam int WIDTH  = 10;
    localparam int HEIGHT = 6;
    localparam int AW     = 4;
    localparam int AH     = 3;
    localparam int FRAME  = WIDTH * HEIGHT;
    localparam int NPIX   = AW * AH;
    localparam int SOF_LAT = 62;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic s_valid;
    logic s_ready;
    logic [3*BW-1:0] s_data;
    logic s_sof;
    logic [BW-1:0] r_out;
    logic [BW-1:0] g_out;
    logic [BW-1:0] b_out;
    logic [3:0] hcount_out;
    logic [2:0] vcount_out;
    logic active_out;
    logic frame_start;
    logic underflow;
    logic err_clear;

    int checks = 0;
    int passes = 0;
    int src_k = 0;
    logic rdy_now;
    logic acc;
    logic [23:0] exp_pix [FRAME];
    logic exp_uf [FRAME];
    logic rdy_log [FRAME];

    always #5 clk = ~clk;

    video_stream_source #(
        .BIT_WIDTH (BW),
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .W_WIDTH   (AW),
        .W_HEIGHT  (AH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .r_out       (r_out),
        .g_out       (g_out),
        .b_out       (b_out),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .active_out  (active_out),
        .frame_start (frame_start),
        .underflow   (underflow),
        .err_clear   (err_clear)
    );

    function automatic logic [23:0] pix(input int k);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = 8'(k + 1);
        g = 8'(k + 64);
        b = 8'(192 - k);
        return {r, g, b};
    endfunction

    function automatic logic [23:0] cleanPix(input int j);
        int hc;
        int vc;
        hc = j % WIDTH;
        vc = j / WIDTH;
        if (hc < AW && vc < AH) begin
            return pix(vc * AW + hc);
        end
        return 24'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: drive at the falling edge, note the handshake, advance the
    // source on acceptance, and return at the next falling edge.
    task automatic applyStimulus(input logic en, input logic gap, input logic fsof,
                                 input logic clr, input logic rs);
        enable    = en;
        s_valid   = !gap;
        s_data    = pix(src_k);
        s_sof     = (src_k == 0) || fsof;
        err_clear = clr;
        rst       = rs;
        #1;
        rdy_now = s_ready;
        acc     = s_valid && s_ready;
        @(posedge clk);
        if (acc === 1'b1) begin
            src_k = (src_k == NPIX - 1) ? 0 : src_k + 1;
        end
        @(negedge clk);
    endtask

    task automatic waitFrameStart(input string name, input int want);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (frame_start !== 1'b1 && n < 200);
        checkOutput({name, " sof_latency"}, n, want);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " rgb"}, {r_out, g_out, b_out}, 0);
        checkOutput({name, " hcount"}, hcount_out, 0);
        checkOutput({name, " vcount"}, vcount_out, 0);
        checkOutput({name, " active"}, active_out, 0);
        checkOutput({name, " frame_start"}, frame_start, 0);
        checkOutput({name, " s_ready"}, s_ready, 0);
        checkOutput({name, " underflow"}, underflow, 0);
    endtask

    // Observe output positions 0..lastJ of one frame against exp_pix/exp_uf,
    // driving the pixel for the following raster position after each check.
    task automatic runFrame(input string name, input int gapPos, input int fsofPos,
                            input int clrPos, input int disPos, input int lastJ,
                            input logic fs0);
        int hc;
        int vc;
        int dp;
        logic a;
        for (int j = 0; j <= lastJ; j++) begin
            hc = j % WIDTH;
            vc = j / WIDTH;
            a  = (hc < AW) && (vc < AH);
            checkOutput($sformatf("%s hcount@%0d", name, j), hcount_out, hc);
            checkOutput($sformatf("%s vcount@%0d", name, j), vcount_out, vc);
            checkOutput($sformatf("%s active@%0d", name, j), active_out, a);
            checkOutput($sformatf("%s rgb@%0d", name, j), {r_out, g_out, b_out}, exp_pix[j]);
            checkOutput($sformatf("%s frame_start@%0d", name, j), frame_start, (j == 0) ? fs0 : 1'b0);
            checkOutput($sformatf("%s underflow@%0d", name, j), underflow, exp_uf[j]);
            dp = (j + 1) % FRAME;
            applyStimulus(dp != disPos, dp == gapPos, dp == fsofPos, dp == clrPos, 1'b0);
            rdy_log[dp] = rdy_now;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        s_valid = 1'b0;
        s_sof = 1'b0;
        s_data = '0;
        err_clear = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkIdle("reset");

        $display("[TB] aligned frame, err_clear without error");
        waitFrameStart("align", SOF_LAT);
        for (int j = 0; j < FRAME; j++) begin
            exp_pix[j] = cleanPix(j);
            exp_uf[j]  = 1'b0;
        end
        runFrame("frame1", -1, -1, 20, -1, FRAME - 1, 1'b1);

        $display("[TB] missing pixel at (2,1) with coincident err_clear");
        for (int j = 0; j < FRAME; j++) begin
            exp_pix[j] = 24'h0;
            exp_uf[j]  = (j >= 12);
        end
        for (int j = 0; j < 4; j++) begin
            exp_pix[j] = pix(j);
        end
        exp_pix[10] = pix(4);
        exp_pix[11] = pix(5);
        exp_pix[13] = pix(6);
        for (int j = 20; j < 24; j++) begin
            exp_pix[j] = pix(j - 13);
        end
        runFrame("gap", 12, -1, 12, -1, FRAME - 1, 1'b1);

        for (int j = 0; j < FRAME; j++) begin
            exp_pix[j] = 24'h0;
            exp_uf[j]  = (j < 30);
        end
        runFrame("resync", -1, -1, 30, -1, FRAME - 1, 1'b0);

        $display("[TB] misplaced start-of-frame at (1,0)");
        for (int j = 0; j < FRAME; j++) begin
            exp_pix[j] = 24'h0;
            exp_uf[j]  = (j >= 1);
        end
        exp_pix[0] = pix(0);
        runFrame("badsof", -1, 1, -1, -1, FRAME - 1, 1'b1);
        checkOutput("badsof ready_at_sof", rdy_log[1], 1);
        checkOutput("badsof ready_drain", rdy_log[5], 1);
        checkOutput("badsof ready_stall", rdy_log[40], 0);
        checkOutput("badsof ready_wrap", rdy_log[59], 0);

        $display("[TB] disable at (3,2)");
        for (int j = 0; j < FRAME; j++) begin
            exp_pix[j] = cleanPix(j);
            exp_uf[j]  = (j < 5);
        end
        runFrame("disable", -1, -1, 5, 23, 22, 1'b1);
        checkIdle("disabled");
        waitFrameStart("reenable", SOF_LAT);

        $display("[TB] reset during RUN");
        for (int j = 0; j < FRAME; j++) begin
            exp_pix[j] = 24'h0;
            exp_uf[j]  = (j >= 2);
        end
        exp_pix[0] = pix(0);
        exp_pix[1] = pix(1);
        exp_pix[3] = pix(2);
        runFrame("prerst", 2, -1, -1, -1, 5, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkIdle("midrst");
        waitFrameStart("post_rst", SOF_LAT);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
